// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one signed multiplier, one accumulator.
// Runtime-loadable taps, valid/ready in and out, scaled/saturated output.
module fir_mac_seq #(
  parameter int DW       = 8,
  parameter int CW       = 8,
  parameter int NTAPS    = 15,
  parameter int OW       = 16,
  parameter int OSHIFT   = 0,
  parameter int SATURATE = 1,
  localparam int TW      = $clog2(NTAPS),
  localparam int AW      = DW + CW + $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  input  logic                 coef_we,
  input  logic [TW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 clear,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_e;

  localparam logic [TW:0]   NTAPS_W = (TW+1)'(NTAPS);
  localparam logic [TW-1:0] KLAST   = TW'(NTAPS - 1);

  state_e                state_q, state_d;
  logic signed [DW-1:0]  x_q [NTAPS];
  logic signed [DW-1:0]  x_d [NTAPS];
  logic signed [CW-1:0]  c_q [NTAPS];
  logic signed [CW-1:0]  c_d [NTAPS];
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [TW-1:0]         k_q, k_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [OW-1:0]  out_data_q, out_data_d;

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    s;
  logic signed [OW-1:0]    scaled;
  logic                    addr_ok;

  assign prod     = x_q[k_q] * c_q[k_q];
  assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
  assign s        = acc_q >>> OSHIFT;
  assign addr_ok  = {1'b0, coef_addr} < NTAPS_W;

  generate
    if (AW > OW) begin : g_narrow
      localparam logic signed [AW-1:0] SMAX =
        {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
      localparam logic signed [AW-1:0] SMIN =
        {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
      always_comb begin
        scaled = s[OW-1:0];
        if (SATURATE != 0) begin
          if (s > SMAX) scaled = SMAX[OW-1:0];
          else if (s < SMIN) scaled = SMIN[OW-1:0];
        end
      end
    end else begin : g_wide
      assign scaled = OW'(s);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (coef_we && addr_ok) c_d[coef_addr] = coef_data;
        if (clear) begin
          for (int j = 0; j < NTAPS; j++) x_d[j] = '0;
        end else if (in_valid) begin
          for (int j = NTAPS - 1; j > 0; j--) x_d[j] = x_q[j-1];
          x_d[0]  = in_data;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + TW'(1);
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        // first OUT cycle latches the finished sum, then we wait for the consumer
        if (!out_valid_q) begin
          out_data_d  = scaled;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int j = 0; j < NTAPS; j++) begin
        x_q[j] <= '0;
        c_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int j = 0; j < NTAPS; j++) begin
        x_q[j] <= x_d[j];
        c_q[j] <= c_d[j];
      end
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE) && !clear;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomized bench for fir_mac_seq against a sum-of-products model.
// Covers impulse, latency, backpressure, saturation, gating and reset.
module tb_fir_mac_seq;

  localparam int NT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              clear;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  int coef [NT];
  int hist [NT];

  fir_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clear     (clear),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_out();
    longint acc = 0;
    for (int j = 0; j < NT; j++) acc += longint'(hist[j]) * coef[j];
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int j = 0; j < NT; j++) begin
      coef[j] = 0;
      hist[j] = 0;
    end
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = a[3:0];
    coef_data = d[7:0];
    tick();
    coef_we = 1'b0;
    if (a < NT) coef[a] = d;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int j = 0; j < NT; j++) hist[j] = 0;
  endtask

  // one full transaction; optional same-cycle or mid-MAC coefficient write
  task automatic send(input int d, input int hold, input bit acc_wr,
                      input bit mac_wr, output longint got);
    int n;
    longint exp;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d[7:0];
    out_ready = 1'b0;
    if (acc_wr) begin
      coef_we   = 1'b1;
      coef_addr = 4'd0;
      coef_data = 8'sd9;
      coef[0]   = 9;
    end
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    for (int j = NT - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = d;
    exp = ref_out();
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      coef_we   = mac_wr && (n == 2);
      coef_addr = 4'd0;
      coef_data = 8'sd55;
      tick();
      n++;
    end
    coef_we = 1'b0;
    check("latency", n, NT + 1);
    got = longint'(out_data);
    check("out_data", got, exp);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      check("bp_in_ready", in_ready, 0);
      tick();
      check("bp_stable", longint'(out_data), got);
      check("bp_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
    check("post_hs_hold", longint'(out_data), got);
  endtask

  initial begin
    longint got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    clear     = 1'b0;
    model_reset();
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("idle_in_ready", in_ready, 1);

    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    do_clear();
    for (int i = 0; i <= NT; i++) begin
      send(i == 0 ? 1 : 0, 0, 1'b0, 1'b0, got);
      check("impulse", got, i < NT ? i + 1 : 0);
    end

    send(37, 5, 1'b0, 1'b0, got);

    do_clear();
    send(1, 0, 1'b0, 1'b1, got);
    check("mac_wr_ignored", got, 1);
    send(0, 0, 1'b0, 1'b0, got);
    check("mac_wr_tap1", got, 2);

    do_clear();
    send(1, 0, 1'b1, 1'b0, got);
    check("same_cycle_wr", got, 9);
    write_coef(0, 1);
    write_coef(15, 77);

    send(5, 0, 1'b0, 1'b0, got);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'sd100;
    #1;
    check("clear_blocks_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_no_accept", busy, 0);
    for (int j = 0; j < NT; j++) hist[j] = 0;
    send(3, 0, 1'b0, 1'b0, got);
    check("clear_history", got, 3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0)
        write_coef(int'($urandom_range(15)),
                   int'($urandom_range(255)) - 128);
      send(int'($urandom_range(255)) - 128,
           int'($urandom_range(2)), 1'b0, 1'b0, got);
    end

    for (int k = 0; k < NT; k++) write_coef(k, 127);
    do_clear();
    for (int i = 0; i < NT; i++) send(127, 0, 1'b0, 1'b0, got);
    check("sat_pos", got, 32767);
    do_clear();
    for (int i = 0; i < NT; i++) send(-128, 0, 1'b0, 1'b0, got);
    check("sat_neg", got, -32768);

    in_valid = 1'b1;
    in_data  = 8'sd50;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mac_busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    send(int'($urandom_range(255)) - 128, 0, 1'b0, 1'b0, got);
    check("post_rst_zero", got, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
